// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: one 8-bit XNOR LFSR shared round-robin by NUM_REQ
// requesters. Each granted requester receives a word that is STEPS fresh
// shifts past the previous one, over a valid/ack handshake. Seed loads
// take priority over requests and are accepted only from IDLE.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   seed_valid  seed load request (held until seed_ready)
//   seed_data   seed value; 8'hFF (lock-up) is replaced by 8'h00
//   seed_ready  one-cycle pulse: seed accepted
//   seed_err    one-cycle pulse with seed_ready when 8'hFF was replaced
//   req         per-requester level request
//   gnt         registered one-hot grant (STEP and DELIVER only)
//   rnd_valid   word available to the granted requester
//   rnd_data    current LFSR register; meaningful while rnd_valid=1
//   rnd_ack     granted requester consumes the word
//   busy        high whenever the FSM is not in IDLE
module lfsr_rand_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned STEPS   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_valid,
  input  logic [7:0]         seed_data,
  output logic               seed_ready,
  output logic               seed_err,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [7:0]         rnd_data,
  input  logic               rnd_ack,
  output logic               busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_ARB,
    S_STEP,
    S_DELIVER
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]      q, q_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [IW-1:0]      idx, idx_n;
  logic [IW-1:0]      last, last_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               rnd_valid_n;
  logic               seed_ready_n;
  logic               seed_err_n;
  logic               busy_n;

  logic [DW-1:0]      shifted_c;
  logic [IW-1:0]      rr_pick_c;
  logic               rr_found_c;

  // One XNOR LFSR shift
  assign shifted_c = {q[6:0], ~(q[7] ^ q[3])};

  // The word handed out is the LFSR register itself; it only moves in STEP
  assign rnd_data = q;

  // Round-robin search starting one past the last served requester
  always_comb begin
    rr_found_c = 1'b0;
    rr_pick_c  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!rr_found_c && req[IW'((32'(last) + i) % NUM_REQ)]) begin
        rr_found_c = 1'b1;
        rr_pick_c  = IW'((32'(last) + i) % NUM_REQ);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    q_n          = q;
    cnt_n        = cnt;
    idx_n        = idx;
    last_n       = last;
    seed_err_n   = 1'b0;
    seed_ready_n = 1'b0;
    busy_n       = 1'b0;
    rnd_valid_n  = 1'b0;
    gnt_n        = '0;

    case (state)
      S_IDLE: begin
        if (seed_valid) begin
          // Seed is captured on the same edge that decides seed_err, so the
          // flag and the loaded value always come from one sample.
          state_n = S_SEED;
          if (seed_data == 8'hFF) begin
            q_n        = '0;
            seed_err_n = 1'b1;
          end else begin
            q_n = seed_data;
          end
        end else if (|req) begin
          state_n = S_ARB;
        end
      end

      S_SEED: begin
        state_n = S_IDLE;
      end

      S_ARB: begin
        if (rr_found_c) begin
          idx_n   = rr_pick_c;
          cnt_n   = CW'(STEPS);
          state_n = S_STEP;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_STEP: begin
        if (!req[idx]) begin
          // Abort: requester loses its turn, shifts already done are kept
          last_n  = idx;
          state_n = S_IDLE;
        end else begin
          q_n   = shifted_c;
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_n = S_DELIVER;
          end
        end
      end

      S_DELIVER: begin
        // A sampled ack wins over a simultaneous request drop
        if (rnd_ack || !req[idx]) begin
          last_n  = idx;
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it
    seed_ready_n = (state_n == S_SEED);
    busy_n       = (state_n != S_IDLE);
    rnd_valid_n  = (state_n == S_DELIVER);
    if ((state_n == S_STEP) || (state_n == S_DELIVER)) begin
      gnt_n = NUM_REQ'(1) << idx_n;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      q          <= '0;
      cnt        <= '0;
      idx        <= '0;
      last       <= IW'(NUM_REQ - 1);
      gnt        <= '0;
      rnd_valid  <= 1'b0;
      seed_ready <= 1'b0;
      seed_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      last       <= last_n;
      gnt        <= gnt_n;
      rnd_valid  <= rnd_valid_n;
      seed_ready <= seed_ready_n;
      seed_err   <= seed_err_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Scoreboard bench for lfsr_rand_arbiter: stimulus pushes expected words and
// seed responses into queues; a negedge monitor pops and compares them.
module tb_lfsr_rand_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned ST = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          seed_valid = 1'b0;
  logic [7:0]    seed_data = 8'h00;
  logic          seed_ready;
  logic          seed_err;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] gnt;
  logic          rnd_valid;
  logic [7:0]    rnd_data;
  logic          rnd_ack = 1'b0;
  logic          busy;

  lfsr_rand_arbiter #(.NUM_REQ(NR), .STEPS(ST)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .seed_err   (seed_err),
    .req        (req),
    .gnt        (gnt),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .rnd_ack    (rnd_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [7:0]    data;
  } word_t;

  word_t wq[$];
  bit    sq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_q     = 0;
  int    m_last  = NR - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: n XNOR-LFSR shifts done arithmetically on an int
  function automatic int lfsr_adv(input int v, input int n);
    int x;
    x = v & 255;
    for (int k = 0; k < n; k++) begin
      x = ((x * 2) & 254) | ((((x >> 7) & 1) == ((x >> 3) & 1)) ? 1 : 0);
    end
    return x;
  endfunction

  // Reference: first requester after 'last' in circular order
  function automatic int rr_pick(input int lst, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(lst + k) % NR]) return (lst + k) % NR;
    end
    return -1;
  endfunction

  task automatic predict(input logic [NR-1:0] r);
    word_t w;
    int j;
    j = rr_pick(m_last, r);
    m_q = lfsr_adv(m_q, ST);
    w.gnt  = NR'(1) << j;
    w.data = 8'(m_q);
    wq.push_back(w);
    m_last = j;
  endtask

  task automatic seed_push(input logic [7:0] d);
    sq.push_back(d == 8'hFF);
    m_q = (d == 8'hFF) ? 0 : int'(d);
  endtask

  task automatic model_reset();
    m_q = 0;
    m_last = NR - 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; seed_valid = 1'b0; rnd_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Waits for rnd_valid; n = negedges waited, -1 on timeout
  task automatic wait_valid(input bit noise, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (rnd_valid === 1'b1) begin
        if (noise) rnd_ack = 1'b0;
        return;
      end
      if (noise) rnd_ack = 1'($urandom_range(0, 1));
    end
    chk("valid_timeout", 0, 1);
    n = -1;
  endtask

  task automatic finish_word(input int ack_dly, input bit noise);
    int n;
    wait_valid(noise, n);
    if (n < 0) return;
    repeat (ack_dly) @(negedge clk);
    rnd_ack = 1'b1;
    @(negedge clk);
    rnd_ack = 1'b0;
    chk("valid_after_ack", rnd_valid, 0);
    chk("gnt_after_ack", gnt, 0);
  endtask

  task automatic word(input logic [NR-1:0] r, input int ack_dly, input bit noise, input bit keep);
    req = r;
    predict(r);
    finish_word(ack_dly, noise);
    if (!keep) req = '0;
  endtask

  task automatic seed_wait();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (seed_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("seed_timeout", 0, 1);
    seed_valid = 1'b0;
  endtask

  task automatic seed(input logic [7:0] d);
    seed_valid = 1'b1;
    seed_data  = d;
    seed_push(d);
    seed_wait();
  endtask

  // Monitor: scoreboard pops plus structural invariants
  logic       prev_v  = 1'b0;
  logic       prev_sr = 1'b0;
  logic [7:0] held    = 8'h00;
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("gnt_outside_busy", 32'((gnt != '0) && !busy), 0);
      chk("valid_without_gnt", 32'(rnd_valid && (gnt == '0)), 0);
      chk("seed_err_alone", 32'(seed_err && !seed_ready), 0);
    end
    if (rnd_valid === 1'b1 && prev_v !== 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        w = wq.pop_front();
        chk("word_gnt", gnt, w.gnt);
        chk("word_data", rnd_data, w.data);
      end
      held = rnd_data;
    end else if (rnd_valid === 1'b1) begin
      chk("data_stable", rnd_data, held);
    end
    if (seed_ready === 1'b1) begin
      if (prev_sr === 1'b1) chk("seed_ready_pulse", 1, 0);
      if (sq.size() == 0) chk("unexpected_seed_ready", 1, 0);
      else chk("seed_err", seed_err, sq.pop_front());
    end
    prev_v  = rnd_valid;
    prev_sr = seed_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NR-1:0] r;

    // Reset values
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rnd_valid, 0);
    chk("rst_seed_ready", seed_ready, 0);
    chk("rst_seed_err", seed_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rnd_data, 0);

    // Ack tied high, requester 0 held: latency and turnaround
    rnd_ack = 1'b1;
    req = 4'b0001;
    for (int k = 0; k < 4; k++) predict(4'b0001);
    wait_valid(1'b0, n);
    chk("first_valid_latency", n, ST + 2);
    for (int k = 1; k < 4; k++) begin
      wait_valid(1'b0, n);
      chk("word_turnaround", n, ST + 3);
    end
    req = '0;
    @(negedge clk);
    rnd_ack = 1'b0;
    @(negedge clk);
    chk("idle_after_stream", busy, 0);

    // Seeds: ordinary value and lock-up value
    seed(8'hA5);
    word(4'b0100, 0, 1'b0, 1'b0);
    seed(8'hFF);
    word(4'b0001, 0, 1'b0, 1'b0);

    // Round robin with all requesting, then a sparse pattern
    do_reset();
    for (int k = 0; k < 6; k++) word(4'b1111, 1, 1'b0, 1'b1);
    word(4'b1010, 1, 1'b0, 1'b0);

    // Seed and request rise together: seed first
    seed_valid = 1'b1; seed_data = 8'h3C; req = 4'b0001;
    seed_push(8'h3C);
    predict(4'b0001);
    @(negedge clk);
    chk("prio_seed_ready", seed_ready, 1);
    chk("prio_gnt", gnt, 0);
    seed_valid = 1'b0;
    finish_word(0, 1'b0);
    req = '0;

    // Seed raised during STEP waits for IDLE
    req = 4'b0010;
    predict(4'b0010);
    repeat (4) @(negedge clk);
    seed_valid = 1'b1; seed_data = 8'h11;
    finish_word(1, 1'b0);
    req = '0;
    chk("seed_held_off", seed_ready, 0);
    seed_push(8'h11);
    seed_wait();
    word(4'b0010, 0, 1'b0, 1'b0);

    // Abort mid-STEP after three shifts
    do_reset();
    req = 4'b0001;
    repeat (5) @(negedge clk);
    req = '0;
    m_q = lfsr_adv(0, 3);
    m_last = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_gnt", gnt, 0);
    chk("abort_valid", rnd_valid, 0);
    word(4'b1111, 0, 1'b0, 1'b0);

    // Reset while delivering
    req = 4'b0100;
    predict(4'b0100);
    wait_valid(1'b0, n);
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("rst_deliver_gnt", gnt, 0);
    chk("rst_deliver_valid", rnd_valid, 0);
    chk("rst_deliver_data", rnd_data, 0);
    chk("rst_deliver_busy", busy, 0);
    reset = 1'b0;
    model_reset();

    // Randomized traffic with stray acks and occasional seeds
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) seed(8'hFF);
        else seed(8'($urandom_range(0, 255)));
      end
      r = NR'($urandom_range(1, 15));
      word(r, int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("words_pending", wq.size(), 0);
    chk("seeds_pending", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
